// File: rtl/jellyvl_etherneco_tx_scheduler.sv
// Periodic TX scheduler: on each trigger, grants pending requesters one packet at a time (index 0 first).
// Optional payload-stall watchdog enabled by JELLYVL_ETHERNECO_TX_SCHEDULER_TIMEOUT_EN.
module jellyvl_etherneco_tx_scheduler #(
    parameter  int NUM_REQ        = 3,
    parameter  int GAP_CYCLES     = 16,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          trigger,

    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][15:0]      req_length,
    input  logic [NUM_REQ-1:0][7:0]       req_type,
    input  logic [NUM_REQ-1:0][7:0]       req_node,
    output logic [NUM_REQ-1:0]            req_start,

    input  logic [NUM_REQ-1:0]            s_payload_last,
    input  logic [NUM_REQ-1:0][7:0]       s_payload_data,
    input  logic [NUM_REQ-1:0]            s_payload_valid,
    output logic [NUM_REQ-1:0]            s_payload_ready,

    output logic                          tx_start,
    output logic                          tx_cancel,
    output logic [15:0]                   tx_length,
    output logic [7:0]                    tx_type,
    output logic [7:0]                    tx_node,

    output logic                          m_payload_last,
    output logic [7:0]                    m_payload_data,
    output logic                          m_payload_valid,
    input  logic                          m_payload_ready,

    output logic                          busy,
    output logic [IDX_W-1:0]              cur_index,
    output logic [15:0]                   overrun_count
);

    typedef enum logic [1:0] {IDLE, START, PAYLOAD, GAP} state_t;

    localparam logic [7:0] GAP_END = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] sel_mask;
    logic [IDX_W-1:0]   sel_idx;
    logic               load;
    logic [7:0]         gap_cnt;
    logic               gap_last;
    logic               hs_last;
    logic               timeout_hit;

    // In IDLE the trigger samples req_valid directly; afterwards the remaining pending bits are served.
    assign sel_mask = (state == IDLE) ? req_valid : pending;

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (sel_mask[i]) sel_idx = IDX_W'(i);
        end
    end

    assign gap_last = (gap_cnt == GAP_END);
    assign hs_last  = m_payload_valid && m_payload_ready && m_payload_last;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger && (|req_valid)) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START:   state_next = (tx_length == 16'd0) ? GAP : PAYLOAD;
            PAYLOAD: begin
                if (hs_last || timeout_hit) state_next = GAP;
            end
            GAP: begin
                if (gap_last) begin
                    if (|pending) begin
                        state_next = START;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pending       <= '0;
            cur_index     <= '0;
            gap_cnt       <= '0;
            overrun_count <= '0;
            tx_length     <= '0;
            tx_type       <= '0;
            tx_node       <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= (state == GAP && !gap_last) ? gap_cnt + 8'd1 : 8'd0;
            if (load) begin
                pending   <= sel_mask & ~(NUM_REQ'(1) << sel_idx);
                cur_index <= sel_idx;
                tx_length <= req_length[sel_idx];
                tx_type   <= req_type[sel_idx];
                tx_node   <= req_node[sel_idx];
            end
            // A trigger outside IDLE never schedules; it is only recorded.
            if (trigger && state != IDLE && overrun_count != 16'hffff) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end
    end

`ifdef JELLYVL_ETHERNECO_TX_SCHEDULER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (state == PAYLOAD) && !m_payload_valid
                         && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == PAYLOAD && !m_payload_valid && !timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign tx_cancel = timeout_hit;
    assign tx_start  = (state == START);
    assign busy      = (state != IDLE);

    assign m_payload_valid = (state == PAYLOAD) && s_payload_valid[cur_index];
    assign m_payload_data  = s_payload_data[cur_index];
    assign m_payload_last  = s_payload_last[cur_index];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req_start[i]       = (state == START) && (cur_index == IDX_W'(i));
        assign s_payload_ready[i] = (state == PAYLOAD) && (cur_index == IDX_W'(i)) && m_payload_ready;
    end

endmodule
